// File: rtl/bcd_operand_entry_if.sv
// Button inputs and operand outputs of the decimal-adder operand entry front end.
// The master drives the raw buttons; the slave (entry block) drives the operands.
interface bcd_operand_entry_if;
  logic       btn_inc;
  logic       btn_next;
  logic       btn_clr;
  logic [3:0] a;
  logic [3:0] b;
  logic       ci;
  logic [1:0] sel;
  logic       op_valid;
  logic       op_load;

  modport master (
    output btn_inc, btn_next, btn_clr,
    input  a, b, ci, sel, op_valid, op_load
  );

  modport slave (
    input  btn_inc, btn_next, btn_clr,
    output a, b, ci, sel, op_valid, op_load
  );
endinterface

// File: rtl/bcd_operand_entry.sv
// Pushbutton operand entry for the single-digit BCD adder: sync + debounce of three
// buttons feeding a field-entry FSM for operand A, operand B and carry-in.
//
// state    | meaning
// ENTER_A  | inc steps operand A (0..9 wrap)
// ENTER_B  | inc steps operand B (0..9 wrap)
// ENTER_CI | inc toggles carry-in
// DONE     | operands final, inc ignored
module bcd_operand_entry #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 20
) (
  input  logic                clk,
  input  logic                rst,
  bcd_operand_entry_if.slave  bus
);

  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    ENTER_CI = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  // Bit order for all button vectors: [0]=inc, [1]=next, [2]=clr.
  logic [2:0]       raw;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       deb_q, deb_d;
  logic [2:0]       deb_dly_q;
  logic [2:0]       press;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       ci_q, ci_d;
  logic       op_valid_q, op_valid_d;
  logic       op_load_q, op_load_d;

  assign raw = {bus.btn_clr, bus.btn_next, bus.btn_inc};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Press pulse lasts exactly one cycle after each debounced rising edge.
  assign press = deb_q & ~deb_dly_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ci_d    = ci_q;
    if (press[2]) begin
      state_d = ENTER_A;
      a_d     = 4'd0;
      b_d     = 4'd0;
      ci_d    = 1'b0;
    end else begin
      if (press[0]) begin
        case (state_q)
          ENTER_A:  a_d  = (a_q >= 4'd9) ? 4'd0 : a_q + 4'd1;
          ENTER_B:  b_d  = (b_q >= 4'd9) ? 4'd0 : b_q + 4'd1;
          ENTER_CI: ci_d = ~ci_q;
          default:  ;
        endcase
      end
      if (press[1]) begin
        case (state_q)
          ENTER_A:  state_d = ENTER_B;
          ENTER_B:  state_d = ENTER_CI;
          ENTER_CI: state_d = DONE;
          default:  state_d = ENTER_A;
        endcase
      end
    end
    op_valid_d = (state_d == DONE);
    op_load_d  = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ENTER_A;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      ci_q       <= 1'b0;
      op_valid_q <= 1'b0;
      op_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ci_q       <= ci_d;
      op_valid_q <= op_valid_d;
      op_load_q  <= op_load_d;
    end
  end

  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.ci       = ci_q;
  assign bus.sel      = state_q;
  assign bus.op_valid = op_valid_q;
  assign bus.op_load  = op_load_q;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed bench for bcd_operand_entry with DEB_CYCLES=16.
module tb_bcd_operand_entry;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   load_cnt = 0;
  int   bad_cnt = 0;

  bcd_operand_entry_if bus();

  bcd_operand_entry #(.DEB_CYCLES(16), .CNT_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.op_load === 1'b1) load_cnt++;
    if (bus.a > 4'd9 || bus.b > 4'd9) bad_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic press(input logic i, input logic n, input logic c);
    @(negedge clk);
    bus.btn_inc = i; bus.btn_next = n; bus.btn_clr = c;
    repeat (25) @(negedge clk);
    bus.btn_inc = 1'b0; bus.btn_next = 1'b0; bus.btn_clr = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  task automatic test_reset;
    bus.btn_inc = 1'b0; bus.btn_next = 1'b0; bus.btn_clr = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_a", bus.a, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_load", bus.op_load, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_a", bus.a, 0);
    chk("idle_b", bus.b, 0);
    chk("idle_ci", bus.ci, 0);
    chk("idle_sel", bus.sel, 0);
    chk("idle_valid", bus.op_valid, 0);
    chk("idle_load_cnt", load_cnt, 0);
  endtask

  task automatic test_debounce;
    int lat;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); bus.btn_inc = 1'b1;
      repeat (10) @(negedge clk); bus.btn_inc = 1'b0;
      repeat (15) @(negedge clk);
    end
    chk("glitch_a", bus.a, 0);
    lat = 0;
    @(negedge clk); bus.btn_inc = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (lat == 0 && bus.a != 4'd0) lat = i;
    end
    @(negedge clk); bus.btn_inc = 1'b0;
    repeat (30) @(negedge clk);
    chk("hold_a_once", bus.a, 1);
    chk("hold_latency_ok", (lat >= 19 && lat <= 20) ? 1 : 0, 1);
  endtask

  task automatic test_enter_a;
    int exp_a;
    press(1'b0, 1'b0, 1'b1);
    chk("clr_a", bus.a, 0);
    exp_a = 0;
    for (int k = 0; k < 11; k++) begin
      press(1'b1, 1'b0, 1'b0);
      exp_a = (exp_a == 9) ? 0 : exp_a + 1;
      chk($sformatf("inc_a_%0d", k), bus.a, exp_a);
    end
    chk("inc_a_final", bus.a, 1);
  endtask

  task automatic test_full_entry;
    press(1'b0, 1'b0, 1'b1);
    load_cnt = 0;
    repeat (4) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    repeat (6) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk("pre_done_load", load_cnt, 0);
    press(1'b0, 1'b1, 1'b0);
    chk("full_a", bus.a, 4);
    chk("full_b", bus.b, 6);
    chk("full_ci", bus.ci, 1);
    chk("full_sel", bus.sel, 3);
    chk("full_valid", bus.op_valid, 1);
    chk("full_load_once", load_cnt, 1);
    repeat (2) press(1'b1, 1'b0, 1'b0);
    chk("done_inc_a", bus.a, 4);
    chk("done_inc_b", bus.b, 6);
    chk("done_inc_ci", bus.ci, 1);
    chk("done_hold_load", load_cnt, 1);
  endtask

  task automatic test_from_done;
    press(1'b0, 1'b1, 1'b0);
    chk("wrap_sel", bus.sel, 0);
    chk("wrap_valid", bus.op_valid, 0);
    chk("wrap_a", bus.a, 4);
    chk("wrap_b", bus.b, 6);
    press(1'b0, 1'b0, 1'b1);
    chk("clr_a2", bus.a, 0);
    chk("clr_b2", bus.b, 0);
    chk("clr_ci2", bus.ci, 0);
  endtask

  task automatic test_simultaneous;
    press(1'b0, 1'b1, 1'b0);
    repeat (9) press(1'b1, 1'b0, 1'b0);
    chk("b_at_9", bus.b, 9);
    press(1'b1, 1'b1, 1'b0);
    chk("incnext_b", bus.b, 0);
    chk("incnext_sel", bus.sel, 2);
    press(1'b0, 1'b0, 1'b1);
    repeat (3) press(1'b1, 1'b0, 1'b0);
    chk("a_at_3", bus.a, 3);
    press(1'b1, 1'b1, 1'b1);
    chk("all3_a", bus.a, 0);
    chk("all3_sel", bus.sel, 0);
  endtask

  task automatic test_reset_mid;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    chk("pre_rst_sel", bus.sel, 1);
    @(negedge clk); bus.btn_next = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_a", bus.a, 0);
    chk("midrst_sel", bus.sel, 0);
    chk("midrst_valid", bus.op_valid, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("held_thru_rst_sel", bus.sel, 1);
    bus.btn_next = 1'b0;
    repeat (30) @(negedge clk);
    chk("held_thru_rst_once", bus.sel, 1);
    chk("never_over_9", bad_cnt, 0);
  endtask

  initial begin
    test_reset;
    test_debounce;
    test_enter_a;
    test_full_entry;
    test_from_done;
    test_simultaneous;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
